// File: rtl/multdiv_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer_pkg
// Shared definitions for the multiply/divide sequencer and the bypass/stall
// unit that watches its in-flight destination register.
//   state_t         : sequencer state encoding (IDLE/START/WAIT/HOLD)
//   CNT_W           : width of the WAIT-cycle timeout counter
//   MULT_EXC_CODE   : exception code written to the status register for mult
//   DIV_EXC_CODE    : exception code written to the status register for div
//   STATUS_REG      : register index that receives exception codes
//   DEF_TIMEOUT     : default number of WAIT cycles before a timeout
// ---------------------------------------------------------------------------
package multdiv_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int CNT_W         = 6;
   localparam int DEF_TIMEOUT   = 40;
   localparam int MULT_EXC_CODE = 4;
   localparam int DIV_EXC_CODE  = 5;
   localparam int STATUS_REG    = 30;

endpackage

// File: rtl/multdiv_timeout_counter.sv
// ---------------------------------------------------------------------------
// multdiv_timeout_counter
// Counts WAIT cycles of the multdiv sequencer and flags the last cycle before
// a missing result is declared a timeout.
//   clock    in  : system clock, rising edge
//   reset    in  : asynchronous, active-low
//   clear    in  : synchronous clear to zero (has priority over enable)
//   enable   in  : increment by one this cycle
//   terminal out : count has reached TERMINAL-1
// ---------------------------------------------------------------------------
module multdiv_timeout_counter
   import multdiv_sequencer_pkg::*;
#(
   parameter int TERMINAL = DEF_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [CNT_W-1:0] count;

   // Clear wins over enable so START can re-arm the counter unconditionally.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // The first WAIT cycle sees count==0, so TERMINAL-1 marks the last one.
   assign terminal = (count == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer
// Launches one mult/div op at a time on the shared multi-cycle unit, stalls
// the pipeline while it runs, holds the result for writeback, converts a hung
// unit into an exception after a timeout, and squashes ops killed by a flush.
//   clock, reset (active-low async)
//   issue_valid/issue_is_div/issue_rd/operand_a/operand_b : op from execute
//   flush          : branch/jump kill of younger instructions
//   md_ctrl_mult/md_ctrl_div/md_operand_a/md_operand_b    : unit launch
//   md_result/md_exception/md_result_rdy                  : unit response
//   stall          : freeze front-end latches
//   wb_valid/wb_rd/wb_data/wb_ack                         : writeback handshake
//   busy_valid/busy_rd : live in-flight destination for bypass/stall logic
// ---------------------------------------------------------------------------
module multdiv_sequencer
   import multdiv_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
   parameter int MULT_EXC       = MULT_EXC_CODE,
   parameter int DIV_EXC        = DIV_EXC_CODE,
   parameter int STATUS_RD      = STATUS_REG
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic        issue_is_div,
   input  logic [4:0]  issue_rd,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic        flush,
   output logic        md_ctrl_mult,
   output logic        md_ctrl_div,
   output logic [31:0] md_operand_a,
   output logic [31:0] md_operand_b,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_result_rdy,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   input  logic        wb_ack,
   output logic        busy_valid,
   output logic [4:0]  busy_rd
);

   state_t      state;
   state_t      state_next;

   logic        squash;
   logic        lat_div;
   logic [4:0]  lat_rd;
   logic [31:0] lat_a;
   logic [31:0] lat_b;
   logic [31:0] res_q;

   logic        load_op;
   logic        set_squash;
   logic        capture;
   logic        capture_exc;
   logic        cnt_clear;
   logic        cnt_en;
   logic        timeout;

   logic [31:0] exc_code;

   assign exc_code = lat_div ? 32'(DIV_EXC) : 32'(MULT_EXC);

   multdiv_timeout_counter #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .clear    (cnt_clear),
      .enable   (cnt_en),
      .terminal (timeout)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Op latches, squash flag and captured result. The operand latches only
   // load in IDLE, which keeps md_operand_a/b stable for the whole op.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         squash  <= 1'b0;
         lat_div <= 1'b0;
         lat_rd  <= '0;
         lat_a   <= '0;
         lat_b   <= '0;
         res_q   <= '0;
      end else begin
         if (load_op) begin
            squash  <= 1'b0;
            lat_div <= issue_is_div;
            lat_rd  <= issue_rd;
            lat_a   <= operand_a;
            lat_b   <= operand_b;
         end
         if (set_squash) begin
            squash <= 1'b1;
         end
         if (capture) begin
            if (capture_exc) begin
               res_q  <= exc_code;
               lat_rd <= 5'(STATUS_RD);
            end else begin
               res_q  <= md_result;
            end
         end
      end
   end

   // Next-state and control decode. Once launched the unit cannot be
   // aborted, so a flush only marks the op as squashed and the sequencer
   // still waits for the unit (or the timeout) before accepting a new op.
   // A result arriving together with the timeout is taken as a real result.
   always_comb begin
      state_next  = state;
      load_op     = 1'b0;
      set_squash  = 1'b0;
      capture     = 1'b0;
      capture_exc = 1'b0;
      cnt_clear   = 1'b0;
      cnt_en      = 1'b0;
      stall       = 1'b0;

      case (state)
         IDLE: begin
            if (issue_valid && !flush) begin
               load_op    = 1'b1;
               stall      = 1'b1;
               state_next = START;
            end
         end
         START: begin
            cnt_clear  = 1'b1;
            stall      = !squash || issue_valid;
            if (flush) begin
               set_squash = 1'b1;
            end
            state_next = WAIT;
         end
         WAIT: begin
            cnt_en = 1'b1;
            stall  = !squash || issue_valid;
            if (flush) begin
               set_squash = 1'b1;
            end
            if (md_result_rdy) begin
               if (squash) begin
                  state_next = IDLE;
               end else begin
                  capture     = 1'b1;
                  capture_exc = md_exception;
                  state_next  = HOLD;
               end
            end else if (timeout) begin
               if (squash) begin
                  state_next = IDLE;
               end else begin
                  capture     = 1'b1;
                  capture_exc = 1'b1;
                  state_next  = HOLD;
               end
            end
         end
         HOLD: begin
            stall = !wb_ack;
            if (wb_ack || flush) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Launch pulses and writeback/bypass views of the latched op.
   assign md_ctrl_mult = (state == START) && !lat_div;
   assign md_ctrl_div  = (state == START) && lat_div;
   assign md_operand_a = lat_a;
   assign md_operand_b = lat_b;
   assign wb_valid     = (state == HOLD);
   assign wb_rd        = (state == HOLD) ? lat_rd : 5'd0;
   assign wb_data      = (state == HOLD) ? res_q : 32'd0;
   assign busy_valid   = (state != IDLE) && !squash;
   assign busy_rd      = lat_rd;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multdiv_sequencer
// Directed self-checking bench for multdiv_sequencer. Inputs are driven 1ns
// after the rising edge and outputs are sampled 1ns after that.
// ---------------------------------------------------------------------------
module tb_multdiv_sequencer;

   logic        clock;
   logic        reset;
   logic        issue_valid;
   logic        issue_is_div;
   logic [4:0]  issue_rd;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        flush;
   logic        md_ctrl_mult;
   logic        md_ctrl_div;
   logic [31:0] md_operand_a;
   logic [31:0] md_operand_b;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_result_rdy;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_ack;
   logic        busy_valid;
   logic [4:0]  busy_rd;

   int checks;
   int errors;

   multdiv_sequencer dut (
      .clock         (clock),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_is_div  (issue_is_div),
      .issue_rd      (issue_rd),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .flush         (flush),
      .md_ctrl_mult  (md_ctrl_mult),
      .md_ctrl_div   (md_ctrl_div),
      .md_operand_a  (md_operand_a),
      .md_operand_b  (md_operand_b),
      .md_result     (md_result),
      .md_exception  (md_exception),
      .md_result_rdy (md_result_rdy),
      .stall         (stall),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .wb_ack        (wb_ack),
      .busy_valid    (busy_valid),
      .busy_rd       (busy_rd)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to 1ns after the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_idle();
      issue_valid   = 1'b0;
      issue_is_div  = 1'b0;
      issue_rd      = 5'd0;
      operand_a     = 32'd0;
      operand_b     = 32'd0;
      flush         = 1'b0;
      md_result     = 32'd0;
      md_exception  = 1'b0;
      md_result_rdy = 1'b0;
      wb_ack        = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      reset = 1'b0;
      step();
      step();
      checks++;
      if ({stall, wb_valid, busy_valid, md_ctrl_mult, md_ctrl_div} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b want 00000",
                  {stall, wb_valid, busy_valid, md_ctrl_mult, md_ctrl_div});
      end
      checks++;
      if ({md_operand_a, md_operand_b, wb_data, wb_rd, busy_rd} !== 106'd0) begin
         errors++;
         $display("[TB] FAIL reset_data: a=%0d b=%0d wbd=%0d wbr=%0d br=%0d want all 0",
                  md_operand_a, md_operand_b, wb_data, wb_rd, busy_rd);
      end
      reset = 1'b1;
      step();
   endtask

   // 7*6, result 33 cycles after the START cycle, immediate ack.
   task automatic test_mult();
      int pulses;
      int stall_low;
      pulses    = 0;
      stall_low = 0;
      issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd9;
      operand_a = 32'd7; operand_b = 32'd6;
      settle();
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mult_issue_stall: got %b want 1", stall);
      end
      step();
      drive_idle();
      settle();
      if (md_ctrl_mult === 1'b1) pulses++;
      checks++;
      if (md_ctrl_div !== 1'b0 || md_operand_a !== 32'd7 || md_operand_b !== 32'd6) begin
         errors++;
         $display("[TB] FAIL mult_start: div=%b a=%0d b=%0d want 0 7 6",
                  md_ctrl_div, md_operand_a, md_operand_b);
      end
      checks++;
      if (busy_valid !== 1'b1 || busy_rd !== 5'd9) begin
         errors++;
         $display("[TB] FAIL mult_busy: valid=%b rd=%0d want 1 9", busy_valid, busy_rd);
      end
      if (stall !== 1'b1) stall_low++;
      for (int k = 1; k <= 33; k++) begin
         step();
         if (k == 33) begin
            md_result_rdy = 1'b1;
            md_result     = 32'd42;
         end
         settle();
         if (md_ctrl_mult === 1'b1) pulses++;
         if (stall !== 1'b1) stall_low++;
      end
      step();
      md_result_rdy = 1'b0;
      md_result     = 32'd0;
      settle();
      if (md_ctrl_mult === 1'b1) pulses++;
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'd42) begin
         errors++;
         $display("[TB] FAIL mult_hold: valid=%b rd=%0d data=%0d want 1 9 42",
                  wb_valid, wb_rd, wb_data);
      end
      if (stall !== 1'b1) stall_low++;
      checks++;
      if (stall_low !== 0) begin
         errors++;
         $display("[TB] FAIL mult_stall_run: low cycles=%0d want 0", stall_low);
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("[TB] FAIL mult_pulse_count: got %0d want 1", pulses);
      end
      wb_ack = 1'b1;
      settle();
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mult_ack_stall: got %b want 0", stall);
      end
      step();
      wb_ack = 1'b0;
      settle();
      checks++;
      if (wb_valid !== 1'b0 || busy_valid !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mult_idle: wbv=%b busy=%b stall=%b want 0 0 0",
                  wb_valid, busy_valid, stall);
      end
   endtask

   // 5/0 with the unit reporting an exception.
   task automatic test_div_by_zero();
      issue_valid = 1'b1; issue_is_div = 1'b1; issue_rd = 5'd12;
      operand_a = 32'd5; operand_b = 32'd0;
      step();
      drive_idle();
      settle();
      checks++;
      if (md_ctrl_div !== 1'b1 || md_ctrl_mult !== 1'b0) begin
         errors++;
         $display("[TB] FAIL div_start_pulse: div=%b mult=%b want 1 0", md_ctrl_div, md_ctrl_mult);
      end
      step();
      step();
      md_result_rdy = 1'b1; md_exception = 1'b1; md_result = 32'hDEAD_BEEF;
      step();
      drive_idle();
      settle();
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd5) begin
         errors++;
         $display("[TB] FAIL div_exc_hold: valid=%b rd=%0d data=%0d want 1 30 5",
                  wb_valid, wb_rd, wb_data);
      end
      checks++;
      if (busy_rd !== 5'd30) begin
         errors++;
         $display("[TB] FAIL div_exc_busy_rd: got %0d want 30", busy_rd);
      end
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;
   endtask

   // Unit never answers: the 40th WAIT cycle is still WAIT, the next is HOLD.
   task automatic test_timeout(input logic is_div, input logic [31:0] code);
      issue_valid = 1'b1; issue_is_div = is_div; issue_rd = 5'd3;
      operand_a = 32'd1; operand_b = 32'd2;
      step();
      drive_idle();
      for (int k = 1; k <= 40; k++) step();
      checks++;
      if (wb_valid !== 1'b0 || stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_early div=%b: wbv=%b stall=%b want 0 1", is_div, wb_valid, stall);
      end
      step();
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== code) begin
         errors++;
         $display("[TB] FAIL timeout_hold div=%b: valid=%b rd=%0d data=%0d want 1 30 %0d",
                  is_div, wb_valid, wb_rd, wb_data, code);
      end
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;
   endtask

   // Flush 3 cycles after issue, then a new issue while the unit still runs.
   task automatic test_flush_wait();
      int stall_low;
      stall_low = 0;
      issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd7;
      operand_a = 32'd3; operand_b = 32'd3;
      step();
      drive_idle();
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      settle();
      checks++;
      if (busy_valid !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_drop: busy=%b stall=%b want 0 0", busy_valid, stall);
      end
      issue_valid = 1'b1; issue_is_div = 1'b1; issue_rd = 5'd11;
      operand_a = 32'd100; operand_b = 32'd7;
      settle();
      if (stall !== 1'b1) stall_low++;
      step();
      if (stall !== 1'b1) stall_low++;
      step();
      md_result_rdy = 1'b1; md_result = 32'd99;
      settle();
      if (stall !== 1'b1) stall_low++;
      step();
      md_result_rdy = 1'b0; md_result = 32'd0;
      settle();
      checks++;
      if (wb_valid !== 1'b0 || busy_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_no_wb: wbv=%b busy=%b want 0 0", wb_valid, busy_valid);
      end
      if (stall !== 1'b1) stall_low++;
      checks++;
      if (stall_low !== 0) begin
         errors++;
         $display("[TB] FAIL flush_new_issue_stall: low cycles=%0d want 0", stall_low);
      end
      step();
      issue_valid = 1'b0;
      settle();
      checks++;
      if (md_ctrl_div !== 1'b1 || md_operand_a !== 32'd100 || busy_rd !== 5'd11) begin
         errors++;
         $display("[TB] FAIL flush_next_start: div=%b a=%0d rd=%0d want 1 100 11",
                  md_ctrl_div, md_operand_a, busy_rd);
      end
      step();
      md_result_rdy = 1'b1; md_result = 32'd14;
      step();
      drive_idle();
      settle();
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd11 || wb_data !== 32'd14) begin
         errors++;
         $display("[TB] FAIL flush_next_hold: valid=%b rd=%0d data=%0d want 1 11 14",
                  wb_valid, wb_rd, wb_data);
      end
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;
   endtask

   // Reach HOLD quickly with a given result.
   task automatic reach_hold(input logic [31:0] res);
      issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd20;
      operand_a = 32'd2; operand_b = 32'd2;
      step();
      drive_idle();
      step();
      md_result_rdy = 1'b1; md_result = res;
      step();
      drive_idle();
   endtask

   task automatic test_hold_flush();
      reach_hold(32'd4);
      flush = 1'b1; wb_ack = 1'b1;
      settle();
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 32'd4 || stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_flush_ack: wbv=%b data=%0d stall=%b want 1 4 0",
                  wb_valid, wb_data, stall);
      end
      step();
      drive_idle();
      settle();
      checks++;
      if (wb_valid !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_flush_ack_idle: wbv=%b stall=%b want 0 0", wb_valid, stall);
      end
      reach_hold(32'd8);
      flush = 1'b1;
      settle();
      checks++;
      if (wb_valid !== 1'b1 || stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_flush_only: wbv=%b stall=%b want 1 1", wb_valid, stall);
      end
      step();
      flush = 1'b0;
      settle();
      checks++;
      if (wb_valid !== 1'b0 || stall !== 1'b0 || busy_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_flush_discard: wbv=%b stall=%b busy=%b want 0 0 0",
                  wb_valid, stall, busy_valid);
      end
   endtask

   task automatic test_async_reset();
      issue_valid = 1'b1; issue_is_div = 1'b1; issue_rd = 5'd17;
      operand_a = 32'd55; operand_b = 32'd11;
      step();
      drive_idle();
      step();
      step();
      reset = 1'b0;
      settle();
      checks++;
      if ({stall, wb_valid, busy_valid, md_ctrl_mult, md_ctrl_div} !== 5'b0 ||
          {md_operand_a, md_operand_b, wb_data, wb_rd, busy_rd} !== 106'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: stall=%b busy=%b a=%0d b=%0d br=%0d want all 0",
                  stall, busy_valid, md_operand_a, md_operand_b, busy_rd);
      end
      #1;
      reset = 1'b1;
      step();
      md_result_rdy = 1'b1; md_result = 32'd5;
      settle();
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_stray_stall: got %b want 0", stall);
      end
      step();
      drive_idle();
      settle();
      checks++;
      if (wb_valid !== 1'b0 || busy_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_stray_rdy: wbv=%b busy=%b want 0 0", wb_valid, busy_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_mult();
      test_div_by_zero();
      test_timeout(1'b0, 32'd4);
      test_timeout(1'b1, 32'd5);
      test_flush_wait();
      test_hold_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
